// File: rtl/ifu_bpu_pkg.sv
// Shared encodings and immediate decoders for the fetch-side branch predictor.
package ifu_bpu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_bpu_bht.sv
// Direct-mapped table of 2-bit saturating counters: sweep write, async lookup, trained update.
module bpu_bht
  import ifu_bpu_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = CNT_WNT
) (
  input  logic             i_clk,
  input  logic             i_init_we,
  input  logic [IDX_W-1:0] i_init_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_upd_we,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] upd_cur;
  logic [1:0] upd_d;

  // Lookup sees the pre-edge value, so a same-cycle update is not bypassed.
  assign o_rd_cnt = cnt_q[i_rd_idx];
  assign upd_cur  = cnt_q[i_upd_idx];

  always_comb begin
    upd_d = upd_cur;
    if (i_upd_taken) begin
      if (upd_cur != CNT_ST) upd_d = upd_cur + 2'd1;
    end else begin
      if (upd_cur != CNT_SNT) upd_d = upd_cur - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_init_we) begin
      cnt_q[i_init_idx] <= INIT_CNT;
    end else if (i_upd_we) begin
      cnt_q[i_upd_idx] <= upd_d;
    end
  end

endmodule

// File: rtl/ifu_bpu.sv
// Fetch-side branch predictor: predecodes B-type/JAL, looks up the BHT and registers
// the prediction for decode.
//   state | meaning
//   INIT  | sweeping INIT_CNT into every BHT entry, fetch stalled, updates dropped
//   RUN   | predicting fetches and training counters from execute
module ifu_bpu
  import ifu_bpu_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         BHT_IDX_W   = 6,
  parameter logic [1:0] INIT_CNT    = 2'b01
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_vld,
  input  logic [XLEN-1:0] i_fetch_iaddr,
  input  logic [31:0]     i_fetch_inst,
  output logic            o_fetch_rdy,
  output logic            o_pred_vld,
  input  logic            i_pred_rdy,
  output logic [XLEN-1:0] o_pred_iaddr,
  output logic [31:0]     o_pred_inst,
  output logic            o_pred_bflag,
  output logic [XLEN-1:0] o_pred_jaddr,
  input  logic            i_flush,
  input  logic            i_upd_vld,
  input  logic            i_upd_isbxx,
  input  logic [XLEN-1:0] i_upd_iaddr,
  input  logic            i_upd_judge
);

  state_e                 state_q;
  logic [BHT_IDX_W-1:0]   sweep_idx_q;
  logic                   pred_vld_q;
  logic [XLEN-1:0]        pred_iaddr_q;
  logic [31:0]            pred_inst_q;
  logic                   pred_bflag_q;
  logic [XLEN-1:0]        pred_jaddr_q;

  logic [1:0]             bht_cnt;
  logic [31:0]            imm32;
  logic                   bflag_d;
  logic [XLEN-1:0]        jaddr_d;
  logic                   fetch_acc;
  logic                   upd_we;

  assign o_fetch_rdy = (state_q == RUN) && (!pred_vld_q || i_pred_rdy);
  assign fetch_acc   = i_fetch_vld && o_fetch_rdy;
  assign upd_we      = (state_q == RUN) && i_upd_vld && i_upd_isbxx;

  bpu_bht #(
    .ENTRIES  (BHT_ENTRIES),
    .IDX_W    (BHT_IDX_W),
    .INIT_CNT (INIT_CNT)
  ) u_bht (
    .i_clk       (i_clk),
    .i_init_we   (state_q == INIT),
    .i_init_idx  (sweep_idx_q),
    .i_rd_idx    (i_fetch_iaddr[BHT_IDX_W+1:2]),
    .o_rd_cnt    (bht_cnt),
    .i_upd_we    (upd_we),
    .i_upd_idx   (i_upd_iaddr[BHT_IDX_W+1:2]),
    .i_upd_taken (i_upd_judge)
  );

  always_comb begin
    imm32   = '0;
    bflag_d = 1'b0;
    case (i_fetch_inst[6:0])
      OPC_BRANCH: begin
        imm32   = imm_b(i_fetch_inst);
        bflag_d = bht_cnt[1];
      end
      OPC_JAL: begin
        imm32   = imm_j(i_fetch_inst);
        bflag_d = 1'b1;
      end
      default: ;
    endcase
    jaddr_d = bflag_d ? i_fetch_iaddr + XLEN'($signed(imm32))
                      : i_fetch_iaddr + XLEN'(4);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= INIT;
      sweep_idx_q  <= '0;
      pred_vld_q   <= 1'b0;
      pred_iaddr_q <= '0;
      pred_inst_q  <= '0;
      pred_bflag_q <= 1'b0;
      pred_jaddr_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (sweep_idx_q == BHT_IDX_W'(BHT_ENTRIES - 1)) state_q <= RUN;
        end
        default: ;
      endcase

      // Flush wins over a same-cycle fetch; the killed fetch is never registered.
      if (i_flush) begin
        pred_vld_q <= 1'b0;
      end else if (fetch_acc) begin
        pred_vld_q   <= 1'b1;
        pred_iaddr_q <= i_fetch_iaddr;
        pred_inst_q  <= i_fetch_inst;
        pred_bflag_q <= bflag_d;
        pred_jaddr_q <= jaddr_d;
      end else if (i_pred_rdy) begin
        pred_vld_q <= 1'b0;
      end
    end
  end

  assign o_pred_vld   = pred_vld_q;
  assign o_pred_iaddr = pred_iaddr_q;
  assign o_pred_inst  = pred_inst_q;
  assign o_pred_bflag = pred_bflag_q;
  assign o_pred_jaddr = pred_jaddr_q;

endmodule

// File: tb/tb_ifu_bpu.sv
// Directed bench for ifu_bpu: reset sweep, BHT training, JAL, backpressure, flush, collision.
module tb_ifu_bpu;

  localparam logic [31:0] BEQ_P20  = 32'h0200_0063;  // beq x0,x0,+0x20
  localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] ADDI     = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] JALR     = 32'h0000_8067;  // jalr x0,0(x1)

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_vld;
  logic [31:0] fetch_iaddr;
  logic [31:0] fetch_inst;
  logic        fetch_rdy;
  logic        pred_vld;
  logic        pred_rdy;
  logic [31:0] pred_iaddr;
  logic [31:0] pred_inst;
  logic        pred_bflag;
  logic [31:0] pred_jaddr;
  logic        flush;
  logic        upd_vld;
  logic        upd_isbxx;
  logic [31:0] upd_iaddr;
  logic        upd_judge;

  int n_chk  = 0;
  int n_fail = 0;
  int n_cyc;

  always #5 clk = ~clk;

  ifu_bpu dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_vld   (fetch_vld),
    .i_fetch_iaddr (fetch_iaddr),
    .i_fetch_inst  (fetch_inst),
    .o_fetch_rdy   (fetch_rdy),
    .o_pred_vld    (pred_vld),
    .i_pred_rdy    (pred_rdy),
    .o_pred_iaddr  (pred_iaddr),
    .o_pred_inst   (pred_inst),
    .o_pred_bflag  (pred_bflag),
    .o_pred_jaddr  (pred_jaddr),
    .i_flush       (flush),
    .i_upd_vld     (upd_vld),
    .i_upd_isbxx   (upd_isbxx),
    .i_upd_iaddr   (upd_iaddr),
    .i_upd_judge   (upd_judge)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count cycles until fetch becomes ready, bounded so a stuck sweep still reports.
  task automatic wait_rdy(output int n);
    n = 0;
    while (fetch_rdy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] inst,
                       input logic bf, input logic [31:0] ja);
    fetch_vld   = 1'b1;
    fetch_iaddr = a;
    fetch_inst  = inst;
    pred_rdy    = 1'b1;
    chk({tag, "_rdy"}, {31'd0, fetch_rdy}, 32'd1);
    tick();
    fetch_vld = 1'b0;
    chk({tag, "_vld"}, {31'd0, pred_vld}, 32'd1);
    chk({tag, "_iaddr"}, pred_iaddr, a);
    chk({tag, "_inst"}, pred_inst, inst);
    chk({tag, "_bflag"}, {31'd0, pred_bflag}, {31'd0, bf});
    chk({tag, "_jaddr"}, pred_jaddr, ja);
    tick();
    chk({tag, "_drain"}, {31'd0, pred_vld}, 32'd0);
  endtask

  task automatic upd(input logic [31:0] a, input logic isb, input logic judge);
    upd_vld   = 1'b1;
    upd_isbxx = isb;
    upd_iaddr = a;
    upd_judge = judge;
    tick();
    upd_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_vld = 1'b0; fetch_iaddr = '0; fetch_inst = '0;
    pred_rdy = 1'b1; flush = 1'b0;
    upd_vld = 1'b0; upd_isbxx = 1'b0; upd_iaddr = '0; upd_judge = 1'b0;
    tick(); tick();
    chk("rst_vld", {31'd0, pred_vld}, 32'd0);
    chk("rst_bflag", {31'd0, pred_bflag}, 32'd0);
    chk("rst_iaddr", pred_iaddr, 32'd0);
    chk("rst_inst", pred_inst, 32'd0);
    chk("rst_jaddr", pred_jaddr, 32'd0);
    chk("rst_frdy", {31'd0, fetch_rdy}, 32'd0);

    rst = 1'b0;
    wait_rdy(n_cyc);
    chk("sweep_len", n_cyc, 32'd64);

    // Restart mid-sweep, and drop an update sent during INIT to an already-swept index.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (30) tick();
    chk("sweep30_frdy", {31'd0, fetch_rdy}, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (40) tick();
    upd(32'h8000_0000, 1'b1, 1'b1);
    wait_rdy(n_cyc);
    chk("resweep_len", n_cyc, 32'd23);
    fetch("init_upd_drop", 32'h8000_0000, BEQ_P20, 1'b0, 32'h8000_0004);

    fetch("cold", 32'h8000_0010, BEQ_P20, 1'b0, 32'h8000_0014);
    upd(32'h8000_0010, 1'b1, 1'b1);
    fetch("train1", 32'h8000_0010, BEQ_P20, 1'b1, 32'h8000_0030);
    repeat (3) upd(32'h8000_0010, 1'b1, 1'b1);
    upd(32'h8000_0010, 1'b1, 1'b0);
    fetch("sat_hi_nt1", 32'h8000_0010, BEQ_P20, 1'b1, 32'h8000_0030);
    repeat (2) upd(32'h8000_0010, 1'b1, 1'b0);
    fetch("nt3", 32'h8000_0010, BEQ_P20, 1'b0, 32'h8000_0014);
    upd(32'h8000_0010, 1'b1, 1'b0);
    upd(32'h8000_0010, 1'b1, 1'b1);
    fetch("sat_lo_t1", 32'h8000_0010, BEQ_P20, 1'b0, 32'h8000_0014);
    upd(32'h8000_0010, 1'b1, 1'b1);
    fetch("sat_lo_t2", 32'h8000_0010, BEQ_P20, 1'b1, 32'h8000_0030);

    fetch("jal", 32'h0000_0100, JAL_M8, 1'b1, 32'h0000_00F8);
    upd(32'h0000_0100, 1'b0, 1'b1);
    fetch("nonbr_upd", 32'h0000_0100, BEQ_P20, 1'b0, 32'h0000_0104);
    fetch("addi", 32'h0000_0200, ADDI, 1'b0, 32'h0000_0204);
    fetch("jalr", 32'h0000_0300, JALR, 1'b0, 32'h0000_0304);
    fetch("wrap", 32'hFFFF_FFFC, ADDI, 1'b0, 32'h0000_0000);

    // Backpressure: hold a JAL prediction while another fetch is offered.
    fetch_vld = 1'b1; fetch_iaddr = 32'h0000_0100; fetch_inst = JAL_M8; pred_rdy = 1'b0;
    tick();
    fetch_iaddr = 32'h0000_0400; fetch_inst = ADDI;
    for (int i = 0; i < 3; i++) begin
      chk("hold_vld", {31'd0, pred_vld}, 32'd1);
      chk("hold_frdy", {31'd0, fetch_rdy}, 32'd0);
      chk("hold_iaddr", pred_iaddr, 32'h0000_0100);
      chk("hold_jaddr", pred_jaddr, 32'h0000_00F8);
      chk("hold_inst", pred_inst, JAL_M8);
      tick();
    end
    flush = 1'b1;
    tick();
    chk("flush_held", {31'd0, pred_vld}, 32'd0);
    pred_rdy = 1'b1;
    chk("flush_frdy", {31'd0, fetch_rdy}, 32'd1);
    tick();
    chk("flush_fetch_drop", {31'd0, pred_vld}, 32'd0);
    flush = 1'b0; fetch_vld = 1'b0;
    tick();
    chk("flush_after", {31'd0, pred_vld}, 32'd0);

    // Index 4 sits at 10; bring it to 01 and collide update with lookup.
    upd(32'h8000_0010, 1'b1, 1'b0);
    fetch_vld = 1'b1; fetch_iaddr = 32'h8000_0110; fetch_inst = BEQ_P20;
    upd_vld = 1'b1; upd_isbxx = 1'b1; upd_iaddr = 32'h8000_0010; upd_judge = 1'b1;
    tick();
    fetch_vld = 1'b0; upd_vld = 1'b0;
    chk("coll_vld", {31'd0, pred_vld}, 32'd1);
    chk("coll_bflag", {31'd0, pred_bflag}, 32'd0);
    chk("coll_jaddr", pred_jaddr, 32'h8000_0114);
    tick();
    fetch("coll_next", 32'h8000_0110, BEQ_P20, 1'b1, 32'h8000_0130);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
